// File: rtl/usb_rx_pkg.sv
// Shared USB receive definitions: controller state encoding and default bit timing.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_RECV     = 3'd2,
    ST_ERR      = 3'd3,
    ST_EOP_WAIT = 3'd4
  } rx_state_t;

  localparam int         CLKS_PER_BIT_DEF = 8;
  localparam int         SAMPLE_PHASE_DEF = 3;
  localparam logic [7:0] SYNC_BYTE_DEF    = 8'h80;

endpackage

// File: rtl/usb_rx_timing_ctrl_if.sv
// Line-side inputs and strobe/status outputs of the USB receive timing controller.
interface usb_rx_timing_ctrl_if;
  import usb_rx_pkg::*;

  // Handshake: there is no valid/ready pair. d_edge, d_orig and eop are sampled
  // on every rising clock edge; shift_enable and byte_received are single-cycle
  // strobes that the consumer must act on in the cycle they are high.
  logic      d_edge;
  logic      d_orig;
  logic      eop;
  logic      shift_enable;
  logic      byte_received;
  logic      rcving;
  logic      r_error;
  rx_state_t dbg_state;

  modport master (
    output d_edge, d_orig, eop,
    input  shift_enable, byte_received, rcving, r_error, dbg_state
  );

  modport slave (
    input  d_edge, d_orig, eop,
    output shift_enable, byte_received, rcving, r_error, dbg_state
  );

endinterface

// File: rtl/bit_phase_counter.sv
// Position within the current USB bit; restarts on every detected line edge.
module bit_phase_counter #(
  parameter  int CLKS_PER_BIT = 8,
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  output logic [PW-1:0] phase
);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q + PW'(1);
    if (clear || (phase_q == PW'(CLKS_PER_BIT - 1))) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/usb_rx_timing_ctrl.sv
// USB receive timing controller: recovers bit strobes, checks the sync byte,
// frames payload bytes and flags framing errors.
module usb_rx_timing_ctrl
  import usb_rx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int         SAMPLE_PHASE = SAMPLE_PHASE_DEF,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input logic                 clk,
  input logic                 n_rst,
  usb_rx_timing_ctrl_if.slave rx
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sync_q, sync_d;
  logic          byte_rcvd_q, byte_rcvd_d;
  logic          rcving_q, rcving_d;
  logic          r_error_q, r_error_d;
  logic [PW-1:0] phase;
  logic          strobe;
  logic [7:0]    sync_next;

  bit_phase_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phase (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (rx.d_edge),
    .phase (phase)
  );

  // A line edge in the sample slot re-aligns the bit, so it suppresses the strobe.
  assign strobe    = ((state_q == ST_SYNC) || (state_q == ST_RECV)) &&
                     (phase == PW'(SAMPLE_PHASE)) && !rx.d_edge;
  assign sync_next = {rx.d_orig, sync_q[7:1]};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sync_d      = sync_q;
    byte_rcvd_d = 1'b0;
    r_error_d   = r_error_q;
    if (strobe) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (rx.d_edge) begin
          state_d   = ST_SYNC;
          bit_cnt_d = '0;
          sync_d    = '0;
          r_error_d = 1'b0;
        end
      end
      ST_SYNC: begin
        if (strobe) begin
          sync_d = sync_next;
          if (rx.eop) begin
            state_d   = ST_EOP_WAIT;
            r_error_d = 1'b1;
          end else if (bit_cnt_q == 3'd7) begin
            if (sync_next == SYNC_BYTE) begin
              state_d = ST_RECV;
            end else begin
              state_d   = ST_ERR;
              r_error_d = 1'b1;
            end
          end
        end
      end
      ST_RECV: begin
        if (strobe) begin
          // An eop is clean only when it lands on a byte boundary.
          if (rx.eop) begin
            state_d = ST_EOP_WAIT;
            if (bit_cnt_q != 3'd0) begin
              r_error_d = 1'b1;
            end
          end else if (bit_cnt_q == 3'd7) begin
            byte_rcvd_d = 1'b1;
          end
        end
      end
      ST_ERR: begin
        r_error_d = 1'b1;
        if (rx.eop) begin
          state_d = ST_EOP_WAIT;
        end
      end
      ST_EOP_WAIT: begin
        if (!rx.eop && !rx.d_edge) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rcving_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      sync_q      <= '0;
      byte_rcvd_q <= 1'b0;
      rcving_q    <= 1'b0;
      r_error_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sync_q      <= sync_d;
      byte_rcvd_q <= byte_rcvd_d;
      rcving_q    <= rcving_d;
      r_error_q   <= r_error_d;
    end
  end

  assign rx.shift_enable  = strobe;
  assign rx.byte_received = byte_rcvd_q;
  assign rx.rcving        = rcving_q;
  assign rx.r_error       = r_error_q;
  assign rx.dbg_state     = state_q;

endmodule

// File: tb/tb_usb_rx_timing_ctrl.sv
// Directed bench for usb_rx_timing_ctrl: sync, payload, error, eop and reset scenarios.
module tb_usb_rx_timing_ctrl;
  import usb_rx_pkg::*;

  logic clk = 1'b0;
  logic n_rst;

  usb_rx_timing_ctrl_if rx_if ();

  usb_rx_timing_ctrl dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx    (rx_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int br_cnt = 0;
  logic [7:0] se_v;
  logic [7:0] br_v;

  always @(negedge clk) begin
    if (rx_if.byte_received === 1'b1) br_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit window of CLKS_PER_BIT cycles; records strobe/pulse per cycle.
  task automatic drive_win(input logic b, input logic e, input int edge_at,
                           output logic [7:0] se_o, output logic [7:0] br_o);
    se_o = '0;
    br_o = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rx_if.d_orig = b;
      rx_if.eop    = e;
      rx_if.d_edge = (c == edge_at);
      #1;
      se_o[c] = rx_if.shift_enable;
      br_o[c] = rx_if.byte_received;
    end
  endtask

  task automatic start_pkt(input string tag);
    @(negedge clk);
    rx_if.d_edge = 1'b1;
    rx_if.d_orig = 1'b0;
    rx_if.eop    = 1'b0;
    #1;
    check_eq($sformatf("%s rcving_before_edge", tag), 32'(rx_if.rcving), 0);
    @(posedge clk);
    #1;
    rx_if.d_edge = 1'b0;
    check_eq($sformatf("%s state_sync", tag), 32'(rx_if.dbg_state), 32'(ST_SYNC));
    check_eq($sformatf("%s rcving_after_edge", tag), 32'(rx_if.rcving), 1);
    check_eq($sformatf("%s r_error_cleared", tag), 32'(rx_if.r_error), 0);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic recv, input string tag);
    logic [7:0] s, b;
    for (int i = 0; i < 8; i++) begin
      drive_win(v[i], 1'b0, -1, s, b);
      check_eq($sformatf("%s se_bit%0d", tag, i), 32'(s), 32'h08);
      check_eq($sformatf("%s br_bit%0d", tag, i), 32'(b), (recv && i == 7) ? 32'h10 : 32'h00);
    end
  endtask

  task automatic j_cycle();
    @(negedge clk);
    rx_if.eop    = 1'b0;
    rx_if.d_edge = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rx_if.d_edge = 1'b0;
    rx_if.d_orig = 1'b0;
    rx_if.eop    = 1'b0;
    n_rst        = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst state", 32'(rx_if.dbg_state), 32'(ST_IDLE));
    check_eq("rst rcving", 32'(rx_if.rcving), 0);
    check_eq("rst shift_enable", 32'(rx_if.shift_enable), 0);
    check_eq("rst byte_received", 32'(rx_if.byte_received), 0);
    check_eq("rst r_error", 32'(rx_if.r_error), 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst idle", 32'(rx_if.dbg_state), 32'(ST_IDLE));
    check_eq("post_rst rcving", 32'(rx_if.rcving), 0);

    // Good packet: sync, A5, 3C, eop on a byte boundary
    br_cnt = 0;
    start_pkt("p1");
    send_byte(8'h80, 1'b0, "p1 sync");
    check_eq("p1 state_recv", 32'(rx_if.dbg_state), 32'(ST_RECV));
    check_eq("p1 r_error_after_sync", 32'(rx_if.r_error), 0);
    send_byte(8'hA5, 1'b1, "p1 a5");
    send_byte(8'h3C, 1'b1, "p1 3c");
    drive_win(1'b0, 1'b1, -1, se_v, br_v);
    check_eq("p1 eop se", 32'(se_v), 32'h08);
    check_eq("p1 eop br", 32'(br_v), 0);
    check_eq("p1 eop_wait", 32'(rx_if.dbg_state), 32'(ST_EOP_WAIT));
    check_eq("p1 eop r_error", 32'(rx_if.r_error), 0);
    j_cycle();
    check_eq("p1 idle", 32'(rx_if.dbg_state), 32'(ST_IDLE));
    check_eq("p1 rcving_idle", 32'(rx_if.rcving), 0);
    check_eq("p1 r_error_end", 32'(rx_if.r_error), 0);
    check_eq("p1 br_count", 32'(br_cnt), 2);

    // Bad sync byte 81
    br_cnt = 0;
    start_pkt("p2");
    send_byte(8'h81, 1'b0, "p2 sync");
    check_eq("p2 state_err", 32'(rx_if.dbg_state), 32'(ST_ERR));
    check_eq("p2 r_error_set", 32'(rx_if.r_error), 1);
    drive_win(1'b1, 1'b0, -1, se_v, br_v);
    check_eq("p2 err_no_se", 32'(se_v), 0);
    check_eq("p2 still_err", 32'(rx_if.dbg_state), 32'(ST_ERR));
    drive_win(1'b0, 1'b1, -1, se_v, br_v);
    check_eq("p2 eop_no_se", 32'(se_v), 0);
    check_eq("p2 eop_wait", 32'(rx_if.dbg_state), 32'(ST_EOP_WAIT));
    check_eq("p2 rcving_eop", 32'(rx_if.rcving), 1);
    j_cycle();
    check_eq("p2 idle", 32'(rx_if.dbg_state), 32'(ST_IDLE));
    check_eq("p2 r_error_sticky", 32'(rx_if.r_error), 1);
    check_eq("p2 rcving_idle", 32'(rx_if.rcving), 0);
    check_eq("p2 br_count", 32'(br_cnt), 0);

    // Partial byte: eop after 4 payload bits (start clears the sticky error)
    br_cnt = 0;
    start_pkt("p3");
    send_byte(8'h80, 1'b0, "p3 sync");
    for (int i = 0; i < 4; i++) begin
      drive_win(i[0], 1'b0, -1, se_v, br_v);
      check_eq($sformatf("p3 se_bit%0d", i), 32'(se_v), 32'h08);
    end
    drive_win(1'b0, 1'b1, -1, se_v, br_v);
    check_eq("p3 eop se", 32'(se_v), 32'h08);
    check_eq("p3 eop br", 32'(br_v), 0);
    check_eq("p3 eop_wait", 32'(rx_if.dbg_state), 32'(ST_EOP_WAIT));
    check_eq("p3 r_error", 32'(rx_if.r_error), 1);
    j_cycle();
    check_eq("p3 idle", 32'(rx_if.dbg_state), 32'(ST_IDLE));
    check_eq("p3 br_count", 32'(br_cnt), 0);

    // Resync edges mid-payload, then reset in the middle of the packet
    start_pkt("p4");
    send_byte(8'h80, 1'b0, "p4 sync");
    drive_win(1'b1, 1'b0, 5, se_v, br_v);
    check_eq("p4 edge_ph5 se", 32'(se_v), 32'h08);
    drive_win(1'b0, 1'b0, -1, se_v, br_v);
    check_eq("p4 resync se", 32'(se_v), 32'h02);
    drive_win(1'b1, 1'b0, 1, se_v, br_v);
    check_eq("p4 edge_on_sample se", 32'(se_v), 32'h20);
    repeat (6) @(negedge clk);
    #1;
    check_eq("p4 pre_rst se", 32'(rx_if.shift_enable), 1);
    check_eq("p4 pre_rst rcving", 32'(rx_if.rcving), 1);
    check_eq("p4 pre_rst state", 32'(rx_if.dbg_state), 32'(ST_RECV));
    #1;
    n_rst = 1'b0;
    #1;
    check_eq("p4 rst se", 32'(rx_if.shift_enable), 0);
    check_eq("p4 rst rcving", 32'(rx_if.rcving), 0);
    check_eq("p4 rst byte_received", 32'(rx_if.byte_received), 0);
    check_eq("p4 rst r_error", 32'(rx_if.r_error), 0);
    check_eq("p4 rst state", 32'(rx_if.dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("p4 released idle", 32'(rx_if.dbg_state), 32'(ST_IDLE));
    check_eq("p4 released rcving", 32'(rx_if.rcving), 0);

    // Clean packet after reset
    br_cnt = 0;
    start_pkt("p5");
    send_byte(8'h80, 1'b0, "p5 sync");
    send_byte(8'h3C, 1'b1, "p5 3c");
    drive_win(1'b0, 1'b1, -1, se_v, br_v);
    check_eq("p5 eop se", 32'(se_v), 32'h08);
    check_eq("p5 eop_wait", 32'(rx_if.dbg_state), 32'(ST_EOP_WAIT));
    j_cycle();
    check_eq("p5 idle", 32'(rx_if.dbg_state), 32'(ST_IDLE));
    check_eq("p5 r_error", 32'(rx_if.r_error), 0);
    check_eq("p5 br_count", 32'(br_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_rx_timing_ctrl.md
USB_RX_TIMING_CTRL -- requirements
Module: usb_rx_timing_ctrl

Interface
REQ-001 Parameters: CLKS_PER_BIT, default 8, clocks per USB bit; SAMPLE_PHASE, default 3, phase index at which a bit is sampled; SYNC_BYTE, default 8'h80, expected decoded sync byte.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 d_edge  input  1  one-cycle pulse from the D+ falling-edge detector.
REQ-005 d_orig  input  1  NRZI-decoded, synchronized bit value.
REQ-006 eop  input  1  end-of-packet (SE0) indication, synchronized.
REQ-007 shift_enable  output  1  one-cycle strobe telling the receive shift register to capture d_orig.
REQ-008 byte_received  output  1  one-cycle pulse after each complete payload byte.
REQ-009 rcving  output  1  high while a packet is in progress.
REQ-010 r_error  output  1  sticky receive-error flag.

Function
REQ-011 Phase counter: 0..CLKS_PER_BIT-1; set to 0 on any cycle with d_edge=1, otherwise increments, wrapping CLKS_PER_BIT-1 -> 0.
REQ-012 shift_enable shall be 1 exactly when state is SYNC or RECV, phase==SAMPLE_PHASE, and d_edge=0; otherwise 0.
REQ-013 Bit counter: 0..7, increments on each shift_enable, wraps 7->0; cleared on entry to SYNC.
REQ-014 Sync register: 8-bit, shifts d_orig in at the MSB (LSB-first arrival) on each shift_enable while in SYNC.
REQ-015 States: IDLE, SYNC, RECV, ERR, EOP_WAIT.
REQ-016 IDLE -> SYNC on d_edge; same cycle clears r_error, the bit counter, and the phase counter.
REQ-017 SYNC: on the 8th shift_enable, the value including the 8th bit is compared; equal to SYNC_BYTE -> RECV, otherwise -> ERR with r_error=1.
REQ-018 SYNC or RECV with eop=1 at a shift_enable cycle -> EOP_WAIT; r_error=1 if the state was SYNC, or if the state was RECV with the bit counter !=0.
REQ-019 RECV: the 8th shift_enable of a byte (bit counter 7) shall assert byte_received in the following cycle for exactly one cycle; no byte_received if eop=1 on that same strobe.
REQ-020 ERR: shift_enable is suppressed; eop=1 on any cycle -> EOP_WAIT; r_error remains 1.
REQ-021 EOP_WAIT -> IDLE on the first cycle with eop=0 and d_edge=0 following the eop deassertion; a d_edge while eop=1 is ignored.
REQ-022 rcving=1 in SYNC, RECV, ERR, and EOP_WAIT; 0 in IDLE; registered.
REQ-023 r_error persists through IDLE until the next IDLE->SYNC transition.
REQ-024 Simultaneous d_edge and phase==SAMPLE_PHASE: the edge wins, phase resets, no strobe that cycle.

Reset
REQ-025 n_rst=0 forces state IDLE, phase 0, bit counter 0, sync register 8'h00, and all outputs 0, immediately and asynchronously, including mid-packet.
REQ-026 After reset release, the block shall be idle and await d_edge; no partial-packet outputs.

Structure
REQ-027 Package usb_rx_pkg holds the state enum typedef, CLKS_PER_BIT, SAMPLE_PHASE, and SYNC_BYTE defaults, shared with the RX datapath.
REQ-028 Single sub-module bit_phase_counter (phase counter with sync-clear and rollover) is instantiated; the FSM and bit counter stay in the top.
REQ-029 All sequential logic is flip-flop based with asynchronous active-low clear; no latches.

Verification
REQ-030 Sync byte 8'h80 bitwise (8 clk/bit) after idle -> shift_enable at phase 3 of every bit, rcving=1 from the cycle after the first d_edge, state RECV, r_error=0.
REQ-031 Sync followed by payload 8'hA5, 8'h3C, then eop at a byte boundary -> two byte_received pulses, return to IDLE, r_error=0.
REQ-032 Sync byte 8'h81 -> state ERR, r_error=1, no shift_enable; after eop and J, IDLE with r_error still 1; next d_edge clears r_error.
REQ-033 eop after 4 payload bits -> EOP_WAIT, r_error=1, no byte_received for the partial byte.
REQ-034 d_edge injected at phase 5 of a bit -> phase restarts at 0 and the next shift_enable occurs 3 cycles later.
REQ-035 n_rst asserted mid-payload -> all outputs 0 in the same cycle; after release, the next packet is received cleanly.
